// File: rtl/instr_issue_pkg.sv
// Shared opcode encoding and decode helpers for the instruction issue controller.
// Values 6 and 7 are unused encodings and are treated as illegal.
package instr_issue_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        MUL = 3'd5
    } opcode_e;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= 3'(MUL);
    endfunction

    function automatic logic is_mul(input logic [2:0] op);
        return op == 3'(MUL);
    endfunction

endpackage

// File: rtl/instr_issue_scoreboard.sv
// Per-register busy bits: one set port, one clear port, three combinational read ports.
// Set wins over clear on the same register; the top never requests both.
module instr_issue_scoreboard #(
    parameter  int NUM_REGS = 8,
    localparam int REG_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [REG_W-1:0] set_idx_i,
    input  logic             clr_i,
    input  logic [REG_W-1:0] clr_idx_i,
    input  logic [REG_W-1:0] rd0_idx_i,
    input  logic [REG_W-1:0] rd1_idx_i,
    input  logic [REG_W-1:0] rd2_idx_i,
    output logic             rd0_busy_o,
    output logic             rd1_busy_o,
    output logic             rd2_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) busy_d[clr_idx_i] = 1'b0;
        if (set_i) busy_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign rd0_busy_o = busy_q[rd0_idx_i];
    assign rd1_busy_o = busy_q[rd1_idx_i];
    assign rd2_busy_o = busy_q[rd2_idx_i];

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue controller: hazard-checked accept, registered issue strobes, shared writeback arbitration.
// MUL support is built only when INSTR_ISSUE_MUL_EN is defined; otherwise MUL is dropped as illegal.
module instr_issue_ctrl
    import instr_issue_pkg::*;
#(
    parameter  int NUM_REGS    = 8,
    parameter  int MUL_LATENCY = 4,
    parameter  int STALL_W     = 16,
    localparam int REG_W       = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_opcode,
    input  logic [REG_W-1:0]   in_op1,
    input  logic [REG_W-1:0]   in_op2,
    input  logic [REG_W-1:0]   in_dest,
    output logic               alu_issue,
    output logic               mul_issue,
    output logic [2:0]         iss_opcode,
    output logic [REG_W-1:0]   iss_op1,
    output logic [REG_W-1:0]   iss_op2,
    output logic [REG_W-1:0]   iss_dest,
    output logic               wb_valid,
    output logic [REG_W-1:0]   wb_dest,
    output logic               wb_unit,
    output logic               illegal,
    output logic [STALL_W-1:0] stall_cnt
);

    logic               busy_op1, busy_op2, busy_dest;
    logic               is_alu_op, is_mul_op;
    logic               unit_conflict, accept;
    logic               go_alu, go_mul, go_ill;
    logic               mul_wb_now;
    logic [REG_W-1:0]   mul_dest;

    logic               alu_issue_q, mul_issue_q, illegal_q;
    logic [2:0]         iss_opcode_q;
    logic [REG_W-1:0]   iss_op1_q, iss_op2_q, iss_dest_q;
    logic               wb_valid_q, wb_unit_q;
    logic [REG_W-1:0]   wb_dest_q;
    logic [STALL_W-1:0] stall_q, stall_d;

    assign is_alu_op = is_legal(in_opcode) & ~is_mul(in_opcode);

`ifdef INSTR_ISSUE_MUL_EN
    // resv_q[k] marks that the MUL owns the writeback port k cycles from now.
    logic [MUL_LATENCY:1] resv_q;
    logic                 mul_busy_q;
    logic [REG_W-1:0]     mul_dest_q;

    assign is_mul_op     = is_mul(in_opcode);
    assign unit_conflict = (is_alu_op & resv_q[2]) | (is_mul_op & mul_busy_q);
    assign mul_wb_now    = resv_q[1];
    assign mul_dest      = mul_dest_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_q     <= '0;
            mul_busy_q <= 1'b0;
            mul_dest_q <= '0;
        end else begin
            resv_q <= {go_mul, resv_q[MUL_LATENCY:2]};
            if (go_mul) begin
                mul_busy_q <= 1'b1;
                mul_dest_q <= in_dest;
            end else if (wb_valid_q && wb_unit_q) begin
                mul_busy_q <= 1'b0;
            end
        end
    end
`else
    assign is_mul_op     = 1'b0;
    assign unit_conflict = 1'b0;
    assign mul_wb_now    = 1'b0;
    assign mul_dest      = '0;
`endif

    assign in_ready = ~rst & ~busy_op1 & ~busy_op2 & ~busy_dest & ~unit_conflict;
    assign accept   = in_valid & in_ready;
    assign go_alu   = accept & is_alu_op;
    assign go_mul   = accept & is_mul_op;
    assign go_ill   = accept & ~is_alu_op & ~is_mul_op;

    instr_issue_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_i      (go_alu | go_mul),
        .set_idx_i  (in_dest),
        .clr_i      (wb_valid_q),
        .clr_idx_i  (wb_dest_q),
        .rd0_idx_i  (in_op1),
        .rd1_idx_i  (in_op2),
        .rd2_idx_i  (in_dest),
        .rd0_busy_o (busy_op1),
        .rd1_busy_o (busy_op2),
        .rd2_busy_o (busy_dest)
    );

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && stall_q != {STALL_W{1'b1}})
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_issue_q  <= 1'b0;
            mul_issue_q  <= 1'b0;
            illegal_q    <= 1'b0;
            iss_opcode_q <= '0;
            iss_op1_q    <= '0;
            iss_op2_q    <= '0;
            iss_dest_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_unit_q    <= 1'b0;
            wb_dest_q    <= '0;
            stall_q      <= '0;
        end else begin
            alu_issue_q <= go_alu;
            mul_issue_q <= go_mul;
            illegal_q   <= go_ill;
            if (go_alu || go_mul) begin
                iss_opcode_q <= in_opcode;
                iss_op1_q    <= in_op1;
                iss_op2_q    <= in_op2;
                iss_dest_q   <= in_dest;
            end
            // ALU and MUL slots are disjoint by construction of the reservation check.
            wb_valid_q <= alu_issue_q | mul_wb_now;
            wb_unit_q  <= ~alu_issue_q & mul_wb_now;
            wb_dest_q  <= alu_issue_q ? iss_dest_q : mul_dest;
            stall_q    <= stall_d;
        end
    end

    assign alu_issue  = alu_issue_q;
    assign mul_issue  = mul_issue_q;
    assign illegal    = illegal_q;
    assign iss_opcode = iss_opcode_q;
    assign iss_op1    = iss_op1_q;
    assign iss_op2    = iss_op2_q;
    assign iss_dest   = iss_dest_q;
    assign wb_valid   = wb_valid_q;
    assign wb_unit    = wb_unit_q;
    assign wb_dest    = wb_dest_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: vector table plus hand sequences, checked by a cycle-stamped scoreboard.
module tb_instr_issue_ctrl;

    localparam int LAT = 4;

`ifdef INSTR_ISSUE_MUL_EN
    localparam int MUL_KIND = 1;
`else
    localparam int MUL_KIND = 2;
`endif

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready;
    logic [2:0]  in_opcode = 0, in_op1 = 0, in_op2 = 0, in_dest = 0;
    logic        alu_issue, mul_issue, wb_valid, wb_unit, illegal;
    logic [2:0]  iss_opcode, iss_op1, iss_op2, iss_dest, wb_dest;
    logic [15:0] stall_cnt;

    instr_issue_ctrl #(.NUM_REGS(8), .MUL_LATENCY(LAT), .STALL_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2), .in_dest(in_dest),
        .alu_issue(alu_issue), .mul_issue(mul_issue), .iss_opcode(iss_opcode),
        .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_dest(iss_dest),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_unit(wb_unit),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct { int cyc; logic mul; logic [2:0] op, r1, r2, rd; } iss_t;
    typedef struct { int cyc; logic unit; logic [2:0] rd; } wb_t;
    iss_t iss_q[$];
    wb_t  wb_q[$];
    int   ill_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 0 = ALU, 1 = MUL, 2 = dropped as illegal
    task automatic send(input logic [2:0] op, r1, r2, rd, input int kind, output int acc);
        bit got = 0;
        acc = -1;
        in_valid = 1; in_opcode = op; in_op1 = r1; in_op2 = r2; in_dest = rd;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                acc = cyc;
                if (kind < 2) begin
                    iss_q.push_back('{acc + 1, kind == 1, op, r1, r2, rd});
                    wb_q.push_back('{(kind == 1) ? acc + 1 + LAT : acc + 2, kind == 1, rd});
                end else begin
                    ill_q.push_back(acc + 1);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!got) chk("send_timeout", 1, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: every strobe must match an expectation stamped with this cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (alu_issue || mul_issue) begin
                int idx = -1;
                foreach (iss_q[i]) if (idx < 0 && iss_q[i].cyc == cyc) idx = i;
                if (idx < 0) chk("issue_unexpected", 1, 0);
                else begin
                    chk("issue_fields",
                        {alu_issue, mul_issue, iss_opcode, iss_op1, iss_op2, iss_dest},
                        {~iss_q[idx].mul, iss_q[idx].mul, iss_q[idx].op,
                         iss_q[idx].r1, iss_q[idx].r2, iss_q[idx].rd});
                    iss_q.delete(idx);
                end
            end
            if (wb_valid) begin
                int idx = -1;
                foreach (wb_q[i]) if (idx < 0 && wb_q[i].cyc == cyc) idx = i;
                if (idx < 0) chk("wb_unexpected", 1, 0);
                else begin
                    chk("wb_fields", {wb_unit, wb_dest}, {wb_q[idx].unit, wb_q[idx].rd});
                    wb_q.delete(idx);
                end
            end
            if (illegal) begin
                int idx = -1;
                foreach (ill_q[i]) if (idx < 0 && ill_q[i] == cyc) idx = i;
                if (idx < 0) chk("illegal_unexpected", 1, 0);
                else begin
                    chk("illegal_pulse", 1, 1);
                    ill_q.delete(idx);
                end
            end
        end
    end

    typedef struct { logic [2:0] op, r1, r2, rd; int kind; int dep_delay; } vec_t;
    vec_t vecs[8];

    initial begin
        int a0, a1;

        vecs[0] = '{3'd0, 3'd1, 3'd2, 3'd3, 0, 3};
        vecs[1] = '{3'd1, 3'd0, 3'd0, 3'd0, 0, 3};
        vecs[2] = '{3'd2, 3'd7, 3'd6, 3'd5, 0, 3};
        vecs[3] = '{3'd3, 3'd4, 3'd4, 3'd4, 0, 3};
        vecs[4] = '{3'd4, 3'd2, 3'd3, 3'd1, 0, 3};
        vecs[5] = '{3'd5, 3'd1, 3'd2, 3'd5, MUL_KIND, (MUL_KIND == 1) ? LAT + 2 : 1};
        vecs[6] = '{3'd6, 3'd1, 3'd2, 3'd3, 2, 1};
        vecs[7] = '{3'd7, 3'd1, 3'd2, 3'd5, 2, 1};

        // Reset state
        #2;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_outputs",
            {alu_issue, mul_issue, wb_valid, wb_unit, illegal, iss_opcode, iss_op1,
             iss_op2, iss_dest, wb_dest, stall_cnt}, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("post_reset_ready", in_ready, 1);
        @(posedge clk); #1;

        // RAW stall: dependant held two cycles, stall counter reaches 2
        send(3'd0, 3'd1, 3'd2, 3'd3, 0, a0);
        send(3'd1, 3'd3, 3'd1, 3'd4, 0, a1);
        chk("raw_accept_cycle", a1 - a0, 3);
        @(negedge clk);
        chk("stall_cnt_raw", stall_cnt, 2);
        idle(6);

        // Vector table: each entry followed next cycle by a reader of its destination
        foreach (vecs[v]) begin
            send(vecs[v].op, vecs[v].r1, vecs[v].r2, vecs[v].rd, vecs[v].kind, a0);
            send(3'd0, vecs[v].rd, vecs[v].rd, vecs[v].rd ^ 3'd4, 0, a1);
            chk($sformatf("dep_delay_v%0d", v), a1 - a0, vecs[v].dep_delay);
            idle(8);
        end

`ifdef INSTR_ISSUE_MUL_EN
        // ALU blocked by the MUL writeback reservation
        send(3'd5, 3'd1, 3'd2, 3'd5, 1, a0);
        idle(2);
        send(3'd0, 3'd0, 3'd1, 3'd2, 0, a1);
        chk("alu_resv_stall", a1 - a0, 4);
        idle(8);

        // Non-pipelined MUL: second MUL waits for the first writeback
        send(3'd5, 3'd1, 3'd2, 3'd5, 1, a0);
        send(3'd5, 3'd3, 3'd4, 3'd6, 1, a1);
        chk("mul_busy_stall", a1 - a0, LAT + 2);
        idle(10);
`endif

        // Reset mid-operation discards in-flight work
        send(3'd5, 3'd1, 3'd2, 3'd5, MUL_KIND, a0);
        idle(2);
        rst = 1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_outputs",
            {alu_issue, mul_issue, wb_valid, wb_unit, illegal, iss_opcode, iss_op1,
             iss_op2, iss_dest, wb_dest, stall_cnt}, 0);
        iss_q.delete(); wb_q.delete(); ill_q.delete();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("midrst_ready_after", in_ready, 1);
        @(posedge clk); #1;
        a1 = cyc;
        send(3'd0, 3'd5, 3'd5, 3'd5, 0, a0);
        chk("midrst_r5_free", a0 - a1, 0);
        idle(10);

        chk("iss_q_drained", iss_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("ill_q_drained", ill_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
